// File: rtl/pwl_sigmoid_eval.sv
// ============================================================================
// Module      : pwl_sigmoid_eval
// Description : 3-stage piecewise-linear (PLAN) sigmoid evaluator with
//               valid/ready streaming on both sides.
//               Optional macro PWL_SEG_TAG_EN adds out_seg (segment index).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwl_sigmoid_eval #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data
`ifdef PWL_SEG_TAG_EN
    ,
    output logic [1:0]        out_seg
`endif
);

    localparam logic [DWIDTH-1:0] c_one     = DWIDTH'(1) << FRAC;
    localparam logic [DWIDTH-1:0] c_half    = DWIDTH'(1) << (FRAC - 1);
    localparam logic [DWIDTH-1:0] c_0p625   = DWIDTH'(5) << (FRAC - 3);
    localparam logic [DWIDTH-1:0] c_0p84375 = DWIDTH'(27) << (FRAC - 5);
    localparam logic [DWIDTH-1:0] c_2p375   = DWIDTH'(19) << (FRAC - 3);
    localparam logic [DWIDTH-1:0] c_five    = DWIDTH'(5) << FRAC;
    localparam logic [DWIDTH-1:0] c_min     = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] c_max     = {1'b0, {(DWIDTH-1){1'b1}}};

    logic              stall;
    logic              v1_q, v2_q, out_valid_q;
    logic              sign1_q, sign2_q;
    logic [DWIDTH-1:0] mag1_q, ya2_q, out_data_q;
    logic [1:0]        seg1_q;
    logic [DWIDTH-1:0] mag_d, ya_d, res_d;
    logic [1:0]        seg_d;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Negating the most-negative input would wrap, so it saturates instead.
    always_comb begin
        mag_d = in_data;
        if (in_data[DWIDTH-1]) begin
            mag_d = (in_data == c_min) ? c_max : -in_data;
        end
        if (mag_d >= c_five) begin
            seg_d = 2'd3;
        end else if (mag_d >= c_2p375) begin
            seg_d = 2'd2;
        end else if (mag_d >= c_one) begin
            seg_d = 2'd1;
        end else begin
            seg_d = 2'd0;
        end
    end

    always_comb begin
        ya_d = c_one;
        case (seg1_q)
            2'd0:    ya_d = (mag1_q >> 2) + c_half;
            2'd1:    ya_d = (mag1_q >> 3) + c_0p625;
            2'd2:    ya_d = (mag1_q >> 5) + c_0p84375;
            default: ya_d = c_one;
        endcase
        if (ya_d > c_one) begin
            ya_d = c_one;
        end
    end

    assign res_d = sign2_q ? (c_one - ya2_q) : ya2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            mag1_q      <= '0;
            seg1_q      <= 2'd0;
            ya2_q       <= '0;
            out_data_q  <= '0;
        end else if (!stall) begin
            v1_q        <= in_valid;
            sign1_q     <= in_data[DWIDTH-1];
            mag1_q      <= mag_d;
            seg1_q      <= seg_d;
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            ya2_q       <= ya_d;
            out_valid_q <= v2_q;
            out_data_q  <= res_d;
        end
    end

`ifdef PWL_SEG_TAG_EN
    logic [1:0] seg2_q, out_seg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg2_q    <= 2'd0;
            out_seg_q <= 2'd0;
        end else if (!stall) begin
            seg2_q    <= seg1_q;
            out_seg_q <= seg2_q;
        end
    end

    assign out_seg = out_seg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwl_sigmoid_eval.sv
// ============================================================================
// Module      : tb_pwl_sigmoid_eval
// Description : Scoreboard bench for pwl_sigmoid_eval with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwl_sigmoid_eval;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
`ifdef PWL_SEG_TAG_EN
    logic [1:0]  out_seg;
`endif

    pwl_sigmoid_eval #(.DWIDTH(32), .FRAC(24)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PWL_SEG_TAG_EN
        ,
        .out_seg   (out_seg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  seg;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_cur = '0;
    logic [1:0]  seg_cur = '0;
    bit          lat_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs and acceptances are both judged at the negedge ahead of the edge that transfers them.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=none", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", out_data, mon_e.data);
`ifdef PWL_SEG_TAG_EN
                    check("out_seg", {30'd0, out_seg}, {30'd0, mon_e.seg});
`endif
                    if (mon_e.lat) check("latency", cyc - mon_e.cyc, 32'd3);
                end
            end
            if (in_valid && in_ready) sb.push_back('{exp_cur, seg_cur, cyc, lat_en});
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] e, input logic [1:0] s);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        exp_cur  = e;
        seg_cur  = s;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=blocked required=accepted");
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", sb.size(), 32'd0);
    endtask

    initial begin
        int   cnt;
        bit   seen;
        logic [31:0] held;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Single zero sample: exactly 0.5 and a one-cycle valid pulse.
        send(32'h0000_0000, 32'h0080_0000, 2'd0);
        in_valid = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("pulse_width", cnt, 32'd1);
        @(posedge clk);
        #1;

        send(32'h0100_0000, 32'h00C0_0000, 2'd1);
        send(32'hFF00_0000, 32'h0040_0000, 2'd1);
        send(32'h0300_0000, 32'h00F0_0000, 2'd2);
        send(32'h0600_0000, 32'h0100_0000, 2'd3);
        send(32'hFA00_0000, 32'h0000_0000, 2'd3);
        send(32'h00FF_FFFF, 32'h00BF_FFFF, 2'd0);
        send(32'h0260_0000, 32'h00EB_0000, 2'd2);
        send(32'hFDA0_0000, 32'h0015_0000, 2'd2);
        send(32'h0500_0000, 32'h0100_0000, 2'd3);
        send(32'h8000_0000, 32'h0000_0000, 2'd3);
        send(32'h0040_0000, 32'h0090_0000, 2'd0);
        send(32'hFFFF_FFFF, 32'h0080_0000, 2'd0);
        drain();

        // Backpressure: outputs freeze and input is refused while stalled.
        lat_en    = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_0000, 32'h0080_0000, 2'd0);
                send(32'h0100_0000, 32'h00C0_0000, 2'd1);
                send(32'hFF00_0000, 32'h0040_0000, 2'd1);
                send(32'h0260_0000, 32'h00EB_0000, 2'd2);
                in_valid = 1'b0;
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("stall_first_seen", {31'd0, seen}, 32'd1);
                held = out_data;
                check("stall_first_data", held, 32'h0080_0000);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_hold_data", out_data, held);
                    check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three samples in flight: nothing stale may emerge.
        lat_en = 1'b1;
        send(32'h0100_0000, 32'h00C0_0000, 2'd1);
        send(32'h0300_0000, 32'h00F0_0000, 2'd2);
        send(32'h0600_0000, 32'h0100_0000, 2'd3);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_reset_out_data", out_data, 32'd0);
        idle(10);
        send(32'hFF00_0000, 32'h0040_0000, 2'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
